vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Sits directly downstream of divisor_clock. Its clk is driven by the divided clk_out (the pixel clock).
- Generates VGA horizontal/vertical timing: hsync, vsync, active-video flag, current pixel coordinates and a start-of-frame pulse.
- Its outputs feed the pixel fetch / RGB output stage that reads the coprocessor's image buffer.
- Default timing is 640x480 @ 60 Hz (800x525 total at 25 MHz).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- CNT_W, 10, width of the counters and coordinate outputs; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  input  1  pixel clock (from divisor_clock clk_out); the block's only clock
- reset_n  input  1  asynchronous, active-low reset
- en  input  1  count enable; when low, all state and outputs hold
- hsync  output  1  horizontal sync, level given by SYNC_POL when asserted
- vsync  output  1  vertical sync, level given by SYNC_POL when asserted
- video_on  output  1  high while the current pixel is inside the active area
- pixel_x  output  CNT_W  horizontal coordinate (h_cnt)
- pixel_y  output  CNT_W  vertical coordinate (v_cnt)
- frame_start  output  1  one-cycle pulse at pixel (0,0)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (async assert, sync release): h_cnt=0, v_cnt=0, hsync=vsync=~SYNC_POL, video_on=0, pixel_x=pixel_y=0, frame_start=0.
- Counters, advancing only on posedge clk with en=1:
  - h_cnt: 0..H_TOTAL-1, then wraps to 0.
  - v_cnt: increments only when h_cnt wraps; wraps to 0 after V_TOTAL-1.
  - Both wrap together on the last pixel of the frame.
- All outputs are registered and decoded from the counter values *before* the update (1-cycle latency). The output cycle after the one where counters=(h,v) shows:
  - pixel_x=h, pixel_y=v
  - video_on = (h<H_ACTIVE) && (v<V_ACTIVE)
  - hsync asserted iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vsync asserted iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491), for entire lines
  - frame_start = (h==0 && v==0)
- en=0: counters and every output register hold, including frame_start. A pulse already registered stays high until the next enabled cycle. Counting resumes exactly where it stopped.
- Reset asserted mid-frame: immediate return to reset values. The first enabled cycle after release emits the (0,0) outputs with frame_start=1.
- No other states; counter values >= TOTAL are unreachable.

Optional Feature:
- Macro: VGA_SYNC_TEST_PATTERN_EN
- Defined: adds output rgb[11:0]. Registered in the same stage as the other outputs; 0 when video_on=0. In the active area it shows 8 vertical color bars, each H_ACTIVE/8 = 80 pixels wide, selected by h[CNT_W-1:..] / 80. Order: white, yellow, cyan, green, magenta, red, blue, black (4 bits per channel, full scale 0xF). Lets the display path be tested without the image buffer.
- Not defined: port absent; no pattern logic.

Decomposition:
- Package vga_pkg:
  - default timing constants (H_/V_ values, totals)
  - CNT_W
  - typedef coord_t = logic [CNT_W-1:0]
  - color bar lookup constants
- One natural sub-module: vga_axis_counter, a generic wrap counter with carry-out (parameter TOTAL), instanced twice. The vertical instance is enabled by the horizontal carry.

Test Plan:
- Reset released, en=1 -> first output cycle: pixel_x=0, pixel_y=0, video_on=1, frame_start=1, hsync=vsync=1 (inactive).
- Free run one line -> hsync=0 for exactly 96 cycles, starting at output pixel_x=656 and ending after 751. video_on falls at pixel_x=640.
- Free run one frame -> vsync=0 for exactly 1600 cycles (lines 490-491). frame_start period = 420000 cycles. pixel_y wraps 524 -> 0 at the same edge pixel_x wraps 799 -> 0.
- en=0 for 10 cycles mid-line at pixel_x=300 -> all outputs frozen. After en=1, pixel_x continues 301, 302, …
- reset_n pulsed low at (x=700, y=491) -> outputs go to reset values without a clock edge. After release, the frame restarts at (0,0) with frame_start=1.
- With VGA_SYNC_TEST_PATTERN_EN: rgb=0xFFF at x=0..79, 0xFF0 at x=80, 0x000 at x=560..639, 0x000 for any x>=640.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared timing constants, coordinate type and colour-bar
//                lookup for the VGA sync generator. Defaults describe
//                640x480 @ 60 Hz (800x525 total at a 25 MHz pixel clock).
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Default horizontal timing (pixels)
    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;
    localparam int c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;

    // Default vertical timing (lines)
    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;
    localparam int c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;

    // Counter / coordinate width; must hold c_h_total-1 and c_v_total-1
    localparam int c_cnt_w = 10;

    typedef logic [c_cnt_w-1:0] coord_t;
    typedef logic [11:0]        rgb_t;

    // Colour bars, 4 bits per channel as {R,G,B}
    localparam rgb_t c_rgb_white   = 12'hFFF;
    localparam rgb_t c_rgb_yellow  = 12'hFF0;
    localparam rgb_t c_rgb_cyan    = 12'h0FF;
    localparam rgb_t c_rgb_green   = 12'h0F0;
    localparam rgb_t c_rgb_magenta = 12'hF0F;
    localparam rgb_t c_rgb_red     = 12'hF00;
    localparam rgb_t c_rgb_blue    = 12'h00F;
    localparam rgb_t c_rgb_black   = 12'h000;

    // Bar index 0 is the leftmost bar
    function automatic rgb_t bar_color(input logic [2:0] idx);
        rgb_t color;
        color = c_rgb_black;
        case (idx)
            3'd0:    color = c_rgb_white;
            3'd1:    color = c_rgb_yellow;
            3'd2:    color = c_rgb_cyan;
            3'd3:    color = c_rgb_green;
            3'd4:    color = c_rgb_magenta;
            3'd5:    color = c_rgb_red;
            3'd6:    color = c_rgb_blue;
            default: color = c_rgb_black;
        endcase
        return color;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axis_counter
//  Description : Generic modulo-TOTAL counter with wrap (carry) output.
//                Counts 0..TOTAL-1 while i_en is high and holds otherwise.
//                o_wrap is combinational: high in the enabled cycle whose
//                clock edge takes the count from TOTAL-1 back to 0, so it
//                can enable a cascaded counter on the same edge.
//  Ports       : clk      - clock
//                reset_n  - asynchronous active-low reset
//                i_en     - count enable
//                o_cnt    - current count (registered)
//                o_wrap   - carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter #(
    parameter int TOTAL = 800,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == c_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = i_en & w_last;

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen
//  Description : VGA horizontal/vertical timing generator running on the
//                pixel clock. Produces hsync, vsync, video_on, pixel
//                coordinates and a start-of-frame pulse. Every output is
//                registered from the counter values before their update,
//                so outputs trail the counters by one enabled cycle.
//  Ports       : clk          - pixel clock (only clock)
//                reset_n      - asynchronous active-low reset
//                en           - count enable; low freezes all state/outputs
//                hsync/vsync  - sync pulses, asserted level = SYNC_POL
//                video_on     - current pixel is inside the active area
//                pixel_x/y    - current pixel coordinates
//                frame_start  - one-cycle pulse at pixel (0,0)
//                rgb          - colour-bar test pattern (optional)
//  Options     : `define VGA_SYNC_TEST_PATTERN_EN to add the rgb output
//                with eight vertical colour bars across the active area.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp,
    parameter bit SYNC_POL = 1'b0,
    parameter int CNT_W    = c_cnt_w
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             frame_start
`ifdef VGA_SYNC_TEST_PATTERN_EN
    ,
    output logic [11:0]      rgb
`endif
);

    localparam int c_h_tot = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_tot = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] c_h_act_end  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_h_sync_beg = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_h_sync_end = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] c_v_act_end  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_v_sync_beg = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_v_sync_end = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_h_wrap;
    logic             w_unused_v_wrap;

    logic             w_video;
    logic             w_hs_act;
    logic             w_vs_act;
    logic             w_origin;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic [CNT_W-1:0] r_pixel_x;
    logic [CNT_W-1:0] r_pixel_y;
    logic             r_frame_start;

    // Horizontal counter runs on en; vertical advances on the horizontal
    // carry, so both wrap on the same edge at the last pixel of a frame.
    vga_axis_counter #(
        .TOTAL (c_h_tot),
        .CNT_W (CNT_W)
    ) u_h_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (en),
        .o_cnt   (w_h_cnt),
        .o_wrap  (w_h_wrap)
    );

    vga_axis_counter #(
        .TOTAL (c_v_tot),
        .CNT_W (CNT_W)
    ) u_v_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_h_wrap),
        .o_cnt   (w_v_cnt),
        .o_wrap  (w_unused_v_wrap)
    );

    // Decode from the pre-update counter values
    assign w_video  = (w_h_cnt < c_h_act_end) && (w_v_cnt < c_v_act_end);
    assign w_hs_act = (w_h_cnt >= c_h_sync_beg) && (w_h_cnt < c_h_sync_end);
    assign w_vs_act = (w_v_cnt >= c_v_sync_beg) && (w_v_cnt < c_v_sync_end);
    assign w_origin = (w_h_cnt == '0) && (w_v_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_frame_start <= 1'b0;
        end else if (en) begin
            r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            r_video_on    <= w_video;
            r_pixel_x     <= w_h_cnt;
            r_pixel_y     <= w_v_cnt;
            r_frame_start <= w_origin;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign frame_start = r_frame_start;

`ifdef VGA_SYNC_TEST_PATTERN_EN
    localparam logic [CNT_W-1:0] c_bar_w = CNT_W'(H_ACTIVE / 8);

    logic [2:0]  w_bar_idx;
    logic [11:0] r_rgb;

    // Index only meaningful inside the active area; blanked otherwise
    assign w_bar_idx = 3'(w_h_cnt / c_bar_w);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb <= 12'h000;
        end else if (en) begin
            r_rgb <= w_video ? bar_color(w_bar_idx) : 12'h000;
        end
    end

    assign rgb = r_rgb;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_gen
//  Description : Directed self-checking bench for vga_sync_gen. Horizontal
//                timing uses the 640-pixel default; vertical timing is
//                shrunk to 10 lines (4 active, 2 FP, 2 sync, 2 BP) so whole
//                frames stay short. A frame is 8000 cycles and vsync spans
//                lines 6..7 (1600 cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 10;
    localparam int FRAME    = 8000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_start;
`ifdef VGA_SYNC_TEST_PATTERN_EN
    logic [11:0] rgb;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    vga_sync_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (1'b0),
        .CNT_W    (10)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start)
`ifdef VGA_SYNC_TEST_PATTERN_EN
        ,
        .rgb         (rgb)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Step negedges until pixel_x==x (and pixel_y==y when y>=0)
    task automatic wait_xy(input int x, input int y, input int max_cyc, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (pixel_x === 10'(x) && (y < 0 || pixel_y === 10'(y))) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        en      = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pixel_x, pixel_y} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_xy: got x=%0d y=%0d, want 0 0", pixel_x, pixel_y);
        end
        n_checks++;
        if ({hsync, vsync, video_on, frame_start} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_flags: got hs,vs,vo,fs=%b, want 1100",
                     {hsync, vsync, video_on, frame_start});
        end
        reset_n = 1'b1;
        en      = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({pixel_x, pixel_y} !== 20'd0) begin
            n_fail++;
            $display("FAIL first_xy: got x=%0d y=%0d, want 0 0", pixel_x, pixel_y);
        end
        n_checks++;
        if ({hsync, vsync, video_on, frame_start} !== 4'b1111) begin
            n_fail++;
            $display("FAIL first_flags: got hs,vs,vo,fs=%b, want 1111",
                     {hsync, vsync, video_on, frame_start});
        end
    endtask

    // Entered with output (0,0) on display; walks the rest of line 0
    task automatic test_line();
        int hs_cnt   = 0;
        int hs_first = -1;
        int hs_last  = -1;
        int vo_fall  = -1;
        int bad_x    = -1;
        for (int i = 1; i < H_TOTAL; i++) begin
            @(negedge clk);
            if ((pixel_x !== 10'(i) || pixel_y !== 10'd0) && bad_x < 0) bad_x = i;
            if (hsync === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
            if (video_on === 1'b0 && vo_fall < 0) vo_fall = i;
        end
        n_checks++;
        if (bad_x >= 0) begin
            n_fail++;
            $display("FAIL line_x_seq: sequence broke at cycle %0d (x=%0d y=%0d)",
                     bad_x, pixel_x, pixel_y);
        end
        n_checks++;
        if (hs_cnt != 96) begin
            n_fail++;
            $display("FAIL hsync_width: got %0d, want 96", hs_cnt);
        end
        n_checks++;
        if (hs_first != 656 || hs_last != 751) begin
            n_fail++;
            $display("FAIL hsync_span: got %0d..%0d, want 656..751", hs_first, hs_last);
        end
        n_checks++;
        if (vo_fall != 640) begin
            n_fail++;
            $display("FAIL video_on_fall: got x=%0d, want 640", vo_fall);
        end
    endtask

    task automatic test_frame();
        bit found = 1'b0;
        int n = 0;
        int vs_cnt = 0;
        int vs_first = -1;
        int vs_last = -1;
        bit wrap_seen = 1'b0;
        bit wrap_ok = 1'b0;
        int prev_x = 0;
        int prev_y = 0;
        // Reach the next frame boundary
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL frame_start_seen: got none in %0d cycles, want one", 2 * FRAME);
            return;
        end
        // Measure one whole frame
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            n++;
            if (vsync === 1'b0) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = n;
                vs_last = n;
            end
            if (pixel_y === 10'd0 && prev_y == V_TOTAL - 1) begin
                wrap_seen = 1'b1;
                wrap_ok   = (prev_x == H_TOTAL - 1) && (pixel_x === 10'd0);
            end
            prev_x = int'(pixel_x);
            prev_y = int'(pixel_y);
            if (frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found || n != FRAME) begin
            n_fail++;
            $display("FAIL frame_period: got %0d cycles, want %0d", n, FRAME);
        end
        n_checks++;
        if (vs_cnt != 1600) begin
            n_fail++;
            $display("FAIL vsync_width: got %0d, want 1600", vs_cnt);
        end
        n_checks++;
        if (vs_first != 4800 || vs_last != 6399) begin
            n_fail++;
            $display("FAIL vsync_span: got %0d..%0d, want 4800..6399", vs_first, vs_last);
        end
        n_checks++;
        if (!(wrap_seen && wrap_ok)) begin
            n_fail++;
            $display("FAIL xy_wrap: got seen=%0d ok=%0d, want 1 1", wrap_seen, wrap_ok);
        end
    endtask

    // Entered with (0,0)/frame_start on display: the pulse must hold with en low
    task automatic test_hold_pulse();
        int bad = 0;
        en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (frame_start !== 1'b1 || pixel_x !== 10'd0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_pulse: got fs=%b x=%0d (%0d bad), want fs=1 x=0",
                     frame_start, pixel_x, bad);
        end
        en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (frame_start !== 1'b0 || pixel_x !== 10'd1) begin
            n_fail++;
            $display("FAIL resume_pulse: got fs=%b x=%0d, want fs=0 x=1", frame_start, pixel_x);
        end
    endtask

    task automatic test_hold_mid();
        bit found;
        int bad = 0;
        wait_xy(300, 0, 2 * H_TOTAL, found);
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL reach_x300: got x=%0d y=%0d, want 300 0", pixel_x, pixel_y);
            return;
        end
        en = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (pixel_x !== 10'd300 || pixel_y !== 10'd0 ||
                {hsync, vsync, video_on, frame_start} !== 4'b1110) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_mid: got x=%0d y=%0d flags=%b (%0d bad), want 300 0 1110",
                     pixel_x, pixel_y, {hsync, vsync, video_on, frame_start}, bad);
        end
        en = 1'b1;
        bad = 0;
        for (int i = 301; i <= 303; i++) begin
            @(negedge clk);
            if (pixel_x !== 10'(i)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL resume_mid: got x=%0d (%0d bad), want 303 after 301,302", pixel_x, bad);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        wait_xy(700, 7, 2 * FRAME, found);
        n_checks++;
        if (!found || vsync !== 1'b0) begin
            n_fail++;
            $display("FAIL reach_700_7: got x=%0d y=%0d vs=%b, want 700 7 0",
                     pixel_x, pixel_y, vsync);
            return;
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({pixel_x, pixel_y} !== 20'd0 ||
            {hsync, vsync, video_on, frame_start} !== 4'b1100) begin
            n_fail++;
            $display("FAIL async_reset: got x=%0d y=%0d flags=%b, want 0 0 1100",
                     pixel_x, pixel_y, {hsync, vsync, video_on, frame_start});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({pixel_x, pixel_y} !== 20'd0 ||
            {hsync, vsync, video_on, frame_start} !== 4'b1111) begin
            n_fail++;
            $display("FAIL restart_origin: got x=%0d y=%0d flags=%b, want 0 0 1111",
                     pixel_x, pixel_y, {hsync, vsync, video_on, frame_start});
        end
        @(negedge clk);
        n_checks++;
        if (pixel_x !== 10'd1 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_next: got x=%0d fs=%b, want 1 0", pixel_x, frame_start);
        end
    endtask

`ifdef VGA_SYNC_TEST_PATTERN_EN
    task automatic test_pattern();
        int          xs  [8] = '{0, 79, 80, 160, 560, 639, 640, 700};
        logic [11:0] exp [8] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'h0FF,
                                 12'h000, 12'h000, 12'h000, 12'h000};
        bit found;
        for (int k = 0; k < 8; k++) begin
            wait_xy(xs[k], 1, 2 * FRAME, found);
            n_checks++;
            if (!found || rgb !== exp[k]) begin
                n_fail++;
                $display("FAIL rgb_x%0d: got %h, want %h", xs[k], rgb, exp[k]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_hold_pulse();
        test_hold_mid();
        test_reset_mid();
`ifdef VGA_SYNC_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
